// File: rtl/aw_wr_arbiter_pkg.sv
// Shared definitions for the two-master AW write arbiter: entry field layout, FSM states, AW struct.
// Optional fixed-priority build is selected with AW_ARB_FIXED_PRIO_EN.
package aw_wr_arbiter_pkg;

    localparam int BURST_LSB  = 0;
    localparam int BURST_MSB  = 1;
    localparam int SIZE_LSB   = 2;
    localparam int SIZE_MSB   = 4;
    localparam int LEN_LSB    = 5;
    localparam int LEN_MSB    = 8;
    localparam int ADDR_LSB   = 9;
    localparam int ADDR_MSB   = 40;
    localparam int ID_LSB     = 41;
    localparam int ID_MSB     = 48;
    localparam int AW_ENTRY_W = ID_MSB + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_AW   = 2'd1,
        ST_W    = 2'd2
    } aw_state_t;

    typedef struct packed {
        logic [7:0]  id;
        logic [31:0] addr;
        logic [3:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
    } aw_entry_t;

    function automatic aw_entry_t unpack_aw(input logic [AW_ENTRY_W-1:0] raw);
        aw_entry_t e;
        e.burst = raw[BURST_MSB:BURST_LSB];
        e.size  = raw[SIZE_MSB:SIZE_LSB];
        e.len   = raw[LEN_MSB:LEN_LSB];
        e.addr  = raw[ADDR_MSB:ADDR_LSB];
        e.id    = raw[ID_MSB:ID_LSB];
        return e;
    endfunction

endpackage

// File: rtl/aw_rr_sel2.sv
// Two-requester grant selector: round-robin on last_grant, or master-0 fixed priority
// when AW_ARB_FIXED_PRIO_EN is defined.
module aw_rr_sel2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       gnt_idx,
    output logic       gnt_any
);

`ifdef AW_ARB_FIXED_PRIO_EN
    logic unused_last_grant;
    assign unused_last_grant = last_grant;

    always_comb begin
        gnt_any = |req;
        gnt_idx = ~req[0];
    end
`else
    // With both requesting, the master that did not win last time goes next.
    always_comb begin
        gnt_any = |req;
        gnt_idx = 1'b0;
        case (req)
            2'b01:   gnt_idx = 1'b0;
            2'b10:   gnt_idx = 1'b1;
            2'b11:   gnt_idx = ~last_grant;
            default: gnt_idx = 1'b0;
        endcase
    end
`endif

endmodule

// File: rtl/aw_wr_arbiter.sv
// Arbitrates two master AW FIFOs onto one slave AW channel, one write outstanding at a time,
// and steers the W channel to the owner. Macro AW_ARB_FIXED_PRIO_EN selects fixed priority.
module aw_wr_arbiter
    import aw_wr_arbiter_pkg::*;
#(
    parameter int DATA_W = 49
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [DATA_W-1:0] m0_rdata,
    input  logic              m0_rempty,
    output logic              m0_rpop,
    input  logic [DATA_W-1:0] m1_rdata,
    input  logic              m1_rempty,
    output logic              m1_rpop,
    output logic [7:0]        s_awid,
    output logic [31:0]       s_awaddr,
    output logic [3:0]        s_awlen,
    output logic [2:0]        s_awsize,
    output logic [1:0]        s_awburst,
    output logic              s_awvalid,
    input  logic              s_awready,
    input  logic              w_last_hs,
    output logic              w_sel,
    output logic              w_sel_valid
);

    aw_state_t         state;
    logic              last_grant;
    logic              gnt_idx;
    logic              gnt_any;
    logic              pop_cycle;
    logic [DATA_W-1:0] head_sel;
    aw_entry_t         head_ent;

    aw_rr_sel2 u_sel (
        .req        ({~m1_rempty, ~m0_rempty}),
        .last_grant (last_grant),
        .gnt_idx    (gnt_idx),
        .gnt_any    (gnt_any)
    );

    // The pop strobe must coincide with the edge that captures the FIFO head, so it is
    // decoded from the registered state; gating with rstn keeps it low during reset.
    always_comb begin
        pop_cycle = rstn && (state == ST_IDLE) && gnt_any;
        m0_rpop   = pop_cycle && !gnt_idx;
        m1_rpop   = pop_cycle && gnt_idx;
        head_sel  = gnt_idx ? m1_rdata : m0_rdata;
        head_ent  = unpack_aw(head_sel[AW_ENTRY_W-1:0]);
    end

`ifdef AW_ARB_FIXED_PRIO_EN
    assign last_grant = 1'b1;
`else
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            last_grant <= 1'b1;
        end else if (pop_cycle) begin
            last_grant <= gnt_idx;
        end
    end
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= ST_IDLE;
            s_awid      <= '0;
            s_awaddr    <= '0;
            s_awlen     <= '0;
            s_awsize    <= '0;
            s_awburst   <= '0;
            s_awvalid   <= 1'b0;
            w_sel       <= 1'b0;
            w_sel_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (gnt_any) begin
                        s_awid    <= head_ent.id;
                        s_awaddr  <= head_ent.addr;
                        s_awlen   <= head_ent.len;
                        s_awsize  <= head_ent.size;
                        s_awburst <= head_ent.burst;
                        s_awvalid <= 1'b1;
                        w_sel     <= gnt_idx;
                        state     <= ST_AW;
                    end
                end
                ST_AW: begin
                    if (s_awready) begin
                        s_awvalid   <= 1'b0;
                        w_sel_valid <= 1'b1;
                        state       <= ST_W;
                    end
                end
                ST_W: begin
                    if (w_last_hs) begin
                        w_sel_valid <= 1'b0;
                        state       <= ST_IDLE;
                    end
                end
                default: begin
                    s_awvalid   <= 1'b0;
                    w_sel_valid <= 1'b0;
                    state       <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aw_wr_arbiter.sv
// Randomized scoreboard bench for aw_wr_arbiter; a transaction-level model predicts grants and
// AW contents while a negedge monitor compares. Honours AW_ARB_FIXED_PRIO_EN like the design.
module tb_aw_wr_arbiter;

    typedef struct packed {
        logic        idx;
        logic [48:0] ent;
    } exp_t;

    logic        clk;
    logic        rstn;
    logic [48:0] m0_rdata;
    logic        m0_rempty;
    logic        m0_rpop;
    logic [48:0] m1_rdata;
    logic        m1_rempty;
    logic        m1_rpop;
    logic [7:0]  s_awid;
    logic [31:0] s_awaddr;
    logic [3:0]  s_awlen;
    logic [2:0]  s_awsize;
    logic [1:0]  s_awburst;
    logic        s_awvalid;
    logic        s_awready;
    logic        w_last_hs;
    logic        w_sel;
    logic        w_sel_valid;

    logic [48:0] fifo0[$];
    logic [48:0] fifo1[$];
    exp_t        exp_q[$];
    exp_t        cur;
    int          phase;
    logic        lg;
    logic        pop0_s;
    logic        pop1_s;
    int          checks;
    int          failures;

    aw_wr_arbiter #(.DATA_W(49)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .m0_rdata    (m0_rdata),
        .m0_rempty   (m0_rempty),
        .m0_rpop     (m0_rpop),
        .m1_rdata    (m1_rdata),
        .m1_rempty   (m1_rempty),
        .m1_rpop     (m1_rpop),
        .s_awid      (s_awid),
        .s_awaddr    (s_awaddr),
        .s_awlen     (s_awlen),
        .s_awsize    (s_awsize),
        .s_awburst   (s_awburst),
        .s_awvalid   (s_awvalid),
        .s_awready   (s_awready),
        .w_last_hs   (w_last_hs),
        .w_sel       (w_sel),
        .w_sel_valid (w_sel_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic predictGrant(input bit ne0, input bit ne1, input logic lastg);
`ifdef AW_ARB_FIXED_PRIO_EN
        return ne0 ? 1'b0 : 1'b1;
`else
        if (ne0 && ne1) return ~lastg;
        return ne0 ? 1'b0 : 1'b1;
`endif
    endfunction

    function automatic logic [48:0] randEntry();
        logic [48:0] e;
        e = {17'($urandom), 32'($urandom)};
        return e;
    endfunction

    task automatic updatePorts();
        m0_rempty = (fifo0.size() == 0);
        m1_rempty = (fifo1.size() == 0);
        m0_rdata  = m0_rempty ? '0 : fifo0[0];
        m1_rdata  = m1_rempty ? '0 : fifo1[0];
    endtask

    // FIFOs retire their head on the edge where the monitor saw the pop strobe.
    task automatic tick();
        @(posedge clk);
        if (pop0_s && fifo0.size() > 0) void'(fifo0.pop_front());
        if (pop1_s && fifo1.size() > 0) void'(fifo1.pop_front());
        #1;
        updatePorts();
    endtask

    task automatic applyStimulus(input int cycles, input int push_pct, input int rdy_pct, input int wl_pct);
        for (int i = 0; i < cycles; i++) begin
            tick();
            if ($urandom_range(99) < push_pct && fifo0.size() < 6) fifo0.push_back(randEntry());
            if ($urandom_range(99) < push_pct && fifo1.size() < 6) fifo1.push_back(randEntry());
            s_awready = ($urandom_range(99) < rdy_pct);
            w_last_hs = ($urandom_range(99) < wl_pct);
            updatePorts();
        end
    endtask

    // Transaction-level reference: free -> address issued -> data phase -> free.
    always @(negedge clk) begin
        int   nxt;
        logic g;
        exp_t item;
        pop0_s = m0_rpop;
        pop1_s = m1_rpop;
        if (rstn) begin
            nxt = phase;
            case (phase)
                0: begin
                    checkOutput("awvalid_idle", s_awvalid, 0);
                    checkOutput("wsel_valid_idle", w_sel_valid, 0);
                    if (fifo0.size() > 0 || fifo1.size() > 0) begin
                        g = predictGrant(fifo0.size() > 0, fifo1.size() > 0, lg);
                        checkOutput("pop0", m0_rpop, (g == 1'b0));
                        checkOutput("pop1", m1_rpop, (g == 1'b1));
                        item.idx = g;
                        item.ent = g ? fifo1[0] : fifo0[0];
                        exp_q.push_back(item);
                        lg  = g;
                        nxt = 1;
                    end else begin
                        checkOutput("pop_when_empty", {m1_rpop, m0_rpop}, 0);
                    end
                end
                1: begin
                    checkOutput("pop_in_aw", {m1_rpop, m0_rpop}, 0);
                    checkOutput("awvalid_aw", s_awvalid, 1);
                    checkOutput("wsel_valid_aw", w_sel_valid, 0);
                    if (exp_q.size() == 0) begin
                        checkOutput("scoreboard_empty", 1, 0);
                    end else begin
                        item = exp_q[0];
                        checkOutput("awid", s_awid, item.ent[48:41]);
                        checkOutput("awaddr", s_awaddr, item.ent[40:9]);
                        checkOutput("awlen", s_awlen, item.ent[8:5]);
                        checkOutput("awsize", s_awsize, item.ent[4:2]);
                        checkOutput("awburst", s_awburst, item.ent[1:0]);
                        if (s_awready) begin
                            cur = exp_q.pop_front();
                            nxt = 2;
                        end
                    end
                end
                default: begin
                    checkOutput("pop_in_w", {m1_rpop, m0_rpop}, 0);
                    checkOutput("awvalid_w", s_awvalid, 0);
                    checkOutput("wsel_valid_w", w_sel_valid, 1);
                    checkOutput("wsel", w_sel, cur.idx);
                    if (w_last_hs) nxt = 0;
                end
            endcase
            phase = nxt;
        end
    end

    initial begin
        checks    = 0;
        failures  = 0;
        phase     = 0;
        lg        = 1'b1;
        pop0_s    = 1'b0;
        pop1_s    = 1'b0;
        cur       = '0;
        rstn      = 1'b0;
        s_awready = 1'b0;
        w_last_hs = 1'b0;
        updatePorts();
        repeat (3) @(posedge clk);

        // Single entry from master 0 with a ready slave.
        fifo0.push_back({8'h12, 32'h1000_0040, 4'h3, 3'h2, 2'h1});
        s_awready = 1'b1;
        updatePorts();
        #1 rstn = 1'b1;
        @(negedge clk);
        checkOutput("first_pop_m0", m0_rpop, 1);
        tick();
        @(negedge clk);
        checkOutput("first_awvalid", s_awvalid, 1);
        checkOutput("first_awid", s_awid, 8'h12);
        checkOutput("first_awaddr", s_awaddr, 32'h1000_0040);
        tick();
        @(negedge clk);
        checkOutput("first_wsel_valid", w_sel_valid, 1);
        checkOutput("first_wsel", w_sel, 0);

        applyStimulus(400, 50, 70, 30);
        applyStimulus(30, 0, 0, 30);
        applyStimulus(400, 90, 90, 50);

        // Reset while the data phase is active.
        for (int i = 0; i < 200 && phase != 2; i++) applyStimulus(1, 30, 60, 0);
        checkOutput("reached_w_phase", (phase == 2), 1);
        fifo0.push_back(randEntry());
        fifo1.push_back(randEntry());
        updatePorts();
        rstn = 1'b0;
        #1;
        checkOutput("rst_awvalid", s_awvalid, 0);
        checkOutput("rst_wsel_valid", w_sel_valid, 0);
        checkOutput("rst_wsel", w_sel, 0);
        checkOutput("rst_awid_addr", {s_awid, s_awaddr}, 0);
        checkOutput("rst_aw_ctrl", {s_awlen, s_awsize, s_awburst}, 0);
        checkOutput("rst_pops", {m1_rpop, m0_rpop}, 0);
        phase = 0;
        lg    = 1'b1;
        exp_q.delete();
        tick();
        tick();
        rstn = 1'b1;
        @(negedge clk);
        checkOutput("post_reset_grant_m0", {m1_rpop, m0_rpop}, 2'b01);

        applyStimulus(300, 90, 80, 40);
        applyStimulus(200, 0, 100, 100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
